clkgen_nco: RTL and testbench

Parametrised multi-channel fractional clock generator: derives up to CHANNELS independent clock-enable strobes and ~50 %-duty derived clocks from one reference clock, using per-channel phase accumulators (NCO). It is the runtime-programmable replacement for fixed-ratio PLL outputs. Typical use is video/CPU pixel and dot enables, such as 35.468 MHz from 50 MHz. A settle counter drives a `locked` output with PLL-like semantics for downstream reset sequencing.

---
 rtl/clkgen_nco.sv | 128 ++++++++++++
 tb/tb_clkgen_nco.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_nco.sv
// clkgen_nco
//   Multi-channel fractional clock generator built from per-channel phase
//   accumulators (NCO). Each channel adds its increment to its accumulator
//   on every refclk edge. The carry out of the add becomes a one-cycle
//   enable strobe, and the accumulator MSB becomes a ~50 % duty clock.
//   A settle counter drives a PLL-style `locked` output. It rises once the
//   configuration has been left alone for SETTLE cycles.
//
// Ports
//   refclk   in   1         reference clock, all logic on its rising edge
//   rst      in   1         synchronous active-high reset
//   cfg_we   in   1         one-cycle increment write strobe
//   cfg_ch   in   CH_W      channel targeted by the write
//   cfg_inc  in   ACC_W     new increment (f_out = f_ref * inc / 2^ACC_W)
//   ce_out   out  CHANNELS  per-channel one-cycle enable strobe
//   clk_out  out  CHANNELS  per-channel derived clock (accumulator MSB)
//   locked   out  1         configuration stable for SETTLE cycles
//
// Handshake: cfg_we is a plain strobe with no back-pressure. Every cycle in
// which cfg_we=1 and cfg_ch < CHANNELS is one accepted write. Any other
// cfg_ch value is discarded without side effects.

module clkgen_nco #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 32,
  parameter int SETTLE   = 1024,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  output logic [CHANNELS-1:0] ce_out,
  output logic [CHANNELS-1:0] clk_out,
  output logic                locked
);

  // The settle counter only needs to reach SETTLE-1. It then holds there.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CH_W:0]    CH_LIMIT    = (CH_W + 1)'(CHANNELS);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  logic [ACC_W-1:0]    inc_r [CHANNELS];
  logic [ACC_W-1:0]    acc_r [CHANNELS];
  logic [CHANNELS-1:0] ce_r;

  lock_state_t         state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;

  logic                valid_wr;

  // Out-of-range channel numbers are filtered here. This one qualifier
  // therefore gates both the channel registers and the lock state machine.
  assign valid_wr = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);

  // Accumulators
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        inc_r[i] <= '0;
        acc_r[i] <= '0;
      end
      ce_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (valid_wr && (cfg_ch == CH_W'(i))) begin
          // A write restarts the channel phase from zero.
          // It applies even when the increment value does not change.
          inc_r[i] <= cfg_inc;
          acc_r[i] <= '0;
          ce_r[i]  <= 1'b0;
        end else begin
          // The add is one bit wider than the accumulator.
          // Its top bit is the wrap carry, and that carry is the enable strobe.
          {ce_r[i], acc_r[i]} <= {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
        end
      end
    end
  end

  always_comb begin
    clk_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clk_out[i] = acc_r[i][ACC_W-1];
    end
  end

  assign ce_out = ce_r;

  // Lock state machine: state register
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= UNLOCKED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Lock state machine: next state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (valid_wr) begin
      state_nxt = UNLOCKED;
      cnt_nxt   = '0;
    end else if (state == UNLOCKED) begin
      // cnt counts the write-free edges after the restart edge.
      // When it reaches SETTLE-1, the edge that follows is the SETTLE-th one.
      if (cnt == SETTLE_LAST) begin
        state_nxt = LOCKED;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // The state encoding is one bit, so locked is the state register itself.
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_clkgen_nco.sv
module tb_clkgen_nco;

  localparam int NCH  = 3;
  localparam int W    = 8;
  localparam int STL  = 16;
  localparam int CHW  = 2;

  localparam int W2   = 32;
  localparam int STL2 = 4;
  localparam longint unsigned INC2 = 64'd3046808567;
  localparam int N2   = 40000;

  // Clock / reset
  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Main DUT: 3 channels, 8-bit accumulators
  logic           rst;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_inc;
  logic [NCH-1:0] ce_out;
  logic [NCH-1:0] clk_out;
  logic           locked;

  clkgen_nco #(.CHANNELS(NCH), .ACC_W(W), .SETTLE(STL)) dut (
    .refclk (refclk),
    .rst    (rst),
    .cfg_we (cfg_we),
    .cfg_ch (cfg_ch),
    .cfg_inc(cfg_inc),
    .ce_out (ce_out),
    .clk_out(clk_out),
    .locked (locked)
  );

  // Second DUT: single channel, 32-bit accumulator, long-run rate check
  logic          rst2;
  logic          cfg_we2;
  logic [0:0]    cfg_ch2;
  logic [W2-1:0] cfg_inc2;
  logic [0:0]    ce_out2;
  logic [0:0]    clk_out2;
  logic          locked2;

  clkgen_nco #(.CHANNELS(1), .ACC_W(W2), .SETTLE(STL2)) dut2 (
    .refclk (refclk),
    .rst    (rst2),
    .cfg_we (cfg_we2),
    .cfg_ch (cfg_ch2),
    .cfg_inc(cfg_inc2),
    .ce_out (ce_out2),
    .clk_out(clk_out2),
    .locked (locked2)
  );

  // Bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model
  // A channel is described by its increment and by the number of edges j
  // since its last write or reset. The ideal phase after j steps is j*inc.
  // The accumulator value is that phase mod 2^W, and a strobe is seen whenever
  // floor(j*inc / 2^W) advanced on the latest step.
  // The lock model counts the edges since the last write or reset.
  longint unsigned m_j   [NCH];
  longint unsigned m_inc [NCH];
  int              m_since;

  task automatic model_step();
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_j[c]   = 0;
        m_inc[c] = 0;
      end
      m_since = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cfg_we && int'(cfg_ch) == c) begin
          m_j[c]   = 0;
          m_inc[c] = longint'(cfg_inc);
        end else begin
          m_j[c]++;
        end
      end
      if (cfg_we && int'(cfg_ch) < NCH) m_since = 0;
      else if (m_since < 1000000) m_since++;
    end
  endtask

  function automatic logic [NCH-1:0] model_ce();
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_j[c] > 0)
        v[c] = ((m_j[c] * m_inc[c]) >> W) != (((m_j[c] - 1) * m_inc[c]) >> W);
    end
    return v;
  endfunction

  function automatic logic [NCH-1:0] model_clk();
    logic [NCH-1:0] v;
    longint unsigned ph;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      ph   = (m_j[c] * m_inc[c]) % (64'd1 << W);
      v[c] = ph >= (64'd1 << (W - 1));
    end
    return v;
  endfunction

  task automatic model_check();
    check("model_ce",     64'(ce_out),  64'(model_ce()));
    check("model_clk",    64'(clk_out), 64'(model_clk()));
    check("model_locked", 64'(locked),  64'(m_since >= STL));
  endtask

  // Driver
  // One clock: the model consumes the inputs sampled at this edge.
  // The DUT outputs are then compared 1 time unit later.
  task automatic do_cycle();
    @(posedge refclk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic drive_idle();
    rst     = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_inc = '0;
  endtask

  // Directed vectors
  // Each entry applies its inputs for one edge and then idles for `idle`
  // further edges. The exp_* values are the outputs after the final edge.
  typedef struct {
    string          name;
    logic           rst;
    logic           we;
    logic [CHW-1:0] ch;
    logic [W-1:0]   inc;
    int             idle;
    logic [NCH-1:0] exp_ce;
    logic [NCH-1:0] exp_clk;
    logic           exp_locked;
  } vec_t;

  vec_t vecs[$];

  initial begin
    drive_idle();
    rst2     = 1'b1;
    cfg_we2  = 1'b0;
    cfg_ch2  = '0;
    cfg_inc2 = '0;
    for (int c = 0; c < NCH; c++) begin
      m_j[c]   = 0;
      m_inc[c] = 0;
    end
    m_since = 0;

    vecs.push_back('{"reset_hold_20",    1'b1, 1'b0, 2'd0, 8'd0,   20, 3'b000, 3'b000, 1'b1});
    vecs.push_back('{"ch0_inc64_j3",     1'b0, 1'b1, 2'd0, 8'd64,   3, 3'b000, 3'b001, 1'b0});
    vecs.push_back('{"ch0_first_pulse",  1'b0, 1'b0, 2'd0, 8'd0,    0, 3'b001, 3'b000, 1'b0});
    vecs.push_back('{"ch1_inc96_write",  1'b0, 1'b1, 2'd1, 8'd96,   0, 3'b000, 3'b000, 1'b0});
    vecs.push_back('{"ch0_ch1_pulse",    1'b0, 1'b0, 2'd0, 8'd0,    2, 3'b011, 3'b000, 1'b0});
    vecs.push_back('{"ch2_inc128",       1'b0, 1'b1, 2'd2, 8'd128,  1, 3'b000, 3'b111, 1'b0});
    vecs.push_back('{"run_to_lock",      1'b0, 1'b0, 2'd0, 8'd0,   19, 3'b000, 3'b101, 1'b1});
    vecs.push_back('{"bad_ch3_ignored",  1'b0, 1'b1, 2'd3, 8'd200,  0, 3'b100, 3'b011, 1'b1});
    vecs.push_back('{"rst_beats_write",  1'b1, 1'b1, 2'd0, 8'd64,   2, 3'b000, 3'b000, 1'b0});
    vecs.push_back('{"inc_still_zero",   1'b0, 1'b0, 2'd0, 8'd0,    9, 3'b000, 3'b000, 1'b0});
    vecs.push_back('{"lock_minus_one",   1'b0, 1'b0, 2'd0, 8'd0,    2, 3'b000, 3'b000, 1'b0});
    vecs.push_back('{"lock_exact",       1'b0, 1'b0, 2'd0, 8'd0,    0, 3'b000, 3'b000, 1'b1});
    vecs.push_back('{"write_drops_lock", 1'b0, 1'b1, 2'd0, 8'd64,   0, 3'b000, 3'b000, 1'b0});

    // Reset-state check
    rst = 1'b1;
    do_cycle();
    check("reset_ce",     64'(ce_out),  64'd0);
    check("reset_clk",    64'(clk_out), 64'd0);
    check("reset_locked", 64'(locked),  64'd0);

    foreach (vecs[k]) begin
      rst     = vecs[k].rst;
      cfg_we  = vecs[k].we;
      cfg_ch  = vecs[k].ch;
      cfg_inc = vecs[k].inc;
      do_cycle();
      drive_idle();
      repeat (vecs[k].idle) do_cycle();
      check({vecs[k].name, "_ce"},     64'(ce_out),  64'(vecs[k].exp_ce));
      check({vecs[k].name, "_clk"},    64'(clk_out), 64'(vecs[k].exp_clk));
      check({vecs[k].name, "_locked"}, 64'(locked),  64'(vecs[k].exp_locked));
    end

    // The lock must re-rise exactly 16 edges after the write that dropped it.
    repeat (STL - 1) do_cycle();
    check("relock_minus_one", 64'(locked), 64'd0);
    do_cycle();
    check("relock_exact", 64'(locked), 64'd1);

    // Randomized stimulus against the model
    for (int n = 0; n < 2500; n++) begin
      int r;
      drive_idle();
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          cfg_we  = 1'b1;
          cfg_inc = W'($urandom_range(1, 255));
        end
      end else if (r < 7) begin
        cfg_we = 1'b1;
        cfg_ch = CHW'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
          0:       cfg_inc = 8'd0;
          1:       cfg_inc = 8'd128;
          2:       cfg_inc = 8'd255;
          3:       cfg_inc = 8'd1;
          default: cfg_inc = W'($urandom_range(0, 255));
        endcase
      end
      do_cycle();
    end
    drive_idle();
    repeat (STL + 4) do_cycle();

    // Long-run rate on the 32-bit instance
    begin
      longint unsigned pulses;
      longint unsigned exp_pulses;
      @(negedge refclk);
      rst2 = 1'b1;
      @(posedge refclk);
      #1;
      rst2     = 1'b0;
      cfg_we2  = 1'b1;
      cfg_ch2  = 1'b0;
      cfg_inc2 = W2'(INC2);
      @(posedge refclk);
      #1;
      cfg_we2 = 1'b0;
      check("w32_after_write_ce",     64'(ce_out2), 64'd0);
      check("w32_after_write_locked", 64'(locked2), 64'd0);
      pulses = 0;
      for (int n = 0; n < N2; n++) begin
        @(posedge refclk);
        #1;
        pulses += longint'(ce_out2);
      end
      exp_pulses = (longint'(N2) * INC2) >> W2;
      check("w32_pulse_count", pulses, exp_pulses);
      check("w32_locked",      64'(locked2), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
